// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: hazard-unit controls, instruction-memory bus,
// execute-stage redirect and the IF/ID register outputs.
interface fetch_stage_if;
  logic        pc_en;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        ihit;
  logic        halt;
  logic [31:0] imemload;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  // The fetch stage itself.
  modport master (
    input  pc_en, if_id_stall, if_id_flush, ihit, halt, imemload,
           redirect_valid, redirect_pc,
    output imemREN, imemaddr, if_id_instr, if_id_npc, if_id_valid, fetch_count
  );

  // Everything around the fetch stage: hazard unit, memory, execute, decode.
  modport slave (
    output pc_en, if_id_stall, if_id_flush, ihit, halt, imemload,
           redirect_valid, redirect_pc,
    input  imemREN, imemaddr, if_id_instr, if_id_npc, if_id_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, pending redirect, IF/ID register.
// Optional fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input logic          CLK,
  input logic          nRST,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (bus.halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.imemREN  = (state_q == FETCH);
    bus.imemaddr = pc_q;
  end

  // A halt sampled in FETCH freezes the PC and discards any redirect that edge.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (state_q == FETCH && !bus.halt) begin
      if (bus.redirect_valid && bus.pc_en) begin
        pc_d         = redirect_tgt;
        pend_valid_d = 1'b0;
      end else if (bus.redirect_valid) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = redirect_tgt;
      end else if (pend_valid_q && bus.pc_en) begin
        pc_d         = pend_pc_q;
        pend_valid_d = 1'b0;
      end else if (bus.pc_en) begin
        pc_d = pc_plus4;
      end
    end
  end

  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (state_q != HALTED) begin
      if (bus.if_id_flush) begin
        instr_d = 32'h0;
        npc_d   = 32'h0;
        valid_d = 1'b0;
      end else if (bus.if_id_stall) begin
        instr_d = instr_q;
      end else if (bus.ihit && state_q == FETCH) begin
        instr_d = bus.imemload;
        npc_d   = pc_plus4;
        valid_d = 1'b1;
      end else begin
        instr_d = 32'h0;
        npc_d   = 32'h0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q         <= PC_INIT;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      instr_q      <= 32'h0;
      npc_q        <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      instr_q      <= instr_d;
      npc_q        <= npc_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.if_id_instr = instr_q;
  assign bus.if_id_npc   = npc_q;
  assign bus.if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_q, count_d;

  // Saturating count of instructions actually accepted by the pipeline.
  always_comb begin
    count_d = count_q;
    if (state_q == FETCH && bus.ihit && bus.pc_en && count_q != 32'hFFFF_FFFF) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= 32'h0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.fetch_count = count_q;
`else
  assign bus.fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with PC_INIT = 0x100.
module tb_fetch_stage;

  localparam logic [31:0] I0 = 32'hA000_0001;
  localparam logic [31:0] I1 = 32'hA000_0002;
  localparam logic [31:0] I2 = 32'hA000_0003;
  localparam logic [31:0] I3 = 32'hA000_0004;
  localparam logic [31:0] I4 = 32'hA000_0005;
  localparam logic [31:0] I5 = 32'hA000_0006;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage #(.PC_INIT(32'h0000_0100)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef FETCH_PERF_CNT_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST = 1'b0;
    bus.pc_en = 1'b0;
    bus.if_id_stall = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.ihit = 1'b0;
    bus.halt = 1'b0;
    bus.imemload = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    @(negedge CLK);
    @(negedge CLK);

    check("reset_ren", bus.imemREN, 32'h0);
    check("reset_addr", bus.imemaddr, 32'h100);
    check("reset_instr", bus.if_id_instr, 32'h0);
    check("reset_npc", bus.if_id_npc, 32'h0);
    check("reset_valid", bus.if_id_valid, 32'h0);
    check("reset_count", bus.fetch_count, 32'h0);

    nRST = 1'b1;
    bus.ihit = 1'b1;
    bus.pc_en = 1'b1;
    bus.imemload = I0;
    tick();
    check("idle_ren", bus.imemREN, 32'h1);
    check("idle_addr", bus.imemaddr, 32'h100);
    check("idle_valid", bus.if_id_valid, 32'h0);

    tick();
    check("f1_addr", bus.imemaddr, 32'h104);
    check("f1_instr", bus.if_id_instr, I0);
    check("f1_npc", bus.if_id_npc, 32'h104);
    check("f1_valid", bus.if_id_valid, 32'h1);
    check("f1_count", bus.fetch_count, exp_cnt(1));

    bus.imemload = I1;
    tick();
    check("f2_addr", bus.imemaddr, 32'h108);
    check("f2_instr", bus.if_id_instr, I1);
    check("f2_npc", bus.if_id_npc, 32'h108);

    bus.imemload = I2;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    tick();
    check("redir20_addr", bus.imemaddr, 32'h20);
    check("redir20_instr", bus.if_id_instr, I2);
    check("redir20_npc", bus.if_id_npc, 32'h10C);
    check("redir20_count", bus.fetch_count, exp_cnt(3));

    bus.redirect_valid = 1'b0;
    bus.pc_en = 1'b0;
    bus.if_id_stall = 1'b1;
    bus.imemload = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", bus.imemaddr, 32'h20);
      check("stall_instr", bus.if_id_instr, I2);
    end
    check("stall_count", bus.fetch_count, exp_cnt(3));

    bus.if_id_stall = 1'b0;
    bus.pc_en = 1'b1;
    bus.imemload = I3;
    tick();
    check("resume_addr", bus.imemaddr, 32'h24);
    check("resume_instr", bus.if_id_instr, I3);
    check("resume_npc", bus.if_id_npc, 32'h24);
    check("resume_count", bus.fetch_count, exp_cnt(4));

    bus.ihit = 1'b0;
    bus.pc_en = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h403;
    tick();
    check("pend_hold_addr", bus.imemaddr, 32'h24);
    check("pend_bubble_valid", bus.if_id_valid, 32'h0);
    bus.redirect_valid = 1'b0;
    tick();
    check("pend_hold2_addr", bus.imemaddr, 32'h24);
    bus.pc_en = 1'b1;
    tick();
    check("pend_apply_addr", bus.imemaddr, 32'h400);

    bus.pc_en = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h500;
    tick();
    check("pend2_hold_addr", bus.imemaddr, 32'h400);
    bus.redirect_pc = 32'h800;
    tick();
    check("pend3_hold_addr", bus.imemaddr, 32'h400);
    bus.redirect_valid = 1'b0;
    bus.pc_en = 1'b1;
    tick();
    check("latest_wins_addr", bus.imemaddr, 32'h800);
    check("latest_wins_count", bus.fetch_count, exp_cnt(4));

    bus.ihit = 1'b1;
    bus.imemload = I4;
    tick();
    check("f4_addr", bus.imemaddr, 32'h804);
    check("f4_instr", bus.if_id_instr, I4);
    check("f4_valid", bus.if_id_valid, 32'h1);
    check("f4_count", bus.fetch_count, exp_cnt(5));

    bus.if_id_flush = 1'b1;
    bus.if_id_stall = 1'b1;
    bus.pc_en = 1'b0;
    bus.imemload = I5;
    tick();
    check("flush_instr", bus.if_id_instr, 32'h0);
    check("flush_npc", bus.if_id_npc, 32'h0);
    check("flush_valid", bus.if_id_valid, 32'h0);
    check("flush_addr", bus.imemaddr, 32'h804);

    bus.if_id_flush = 1'b0;
    bus.if_id_stall = 1'b0;
    bus.ihit = 1'b0;
    bus.pc_en = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    check("top_addr", bus.imemaddr, 32'hFFFF_FFFC);

    bus.redirect_valid = 1'b0;
    bus.ihit = 1'b1;
    bus.imemload = I5;
    tick();
    check("wrap_addr", bus.imemaddr, 32'h0);
    check("wrap_instr", bus.if_id_instr, I5);
    check("wrap_npc", bus.if_id_npc, 32'h0);
    check("wrap_valid", bus.if_id_valid, 32'h1);
    check("wrap_count", bus.fetch_count, exp_cnt(6));

    bus.halt = 1'b1;
    bus.pc_en = 1'b0;
    bus.ihit = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    check("halt_ren", bus.imemREN, 32'h0);
    check("halt_addr", bus.imemaddr, 32'h0);
    bus.pc_en = 1'b1;
    bus.ihit = 1'b1;
    tick();
    tick();
    check("halted_ren", bus.imemREN, 32'h0);
    check("halted_addr", bus.imemaddr, 32'h0);
    check("halted_valid", bus.if_id_valid, 32'h0);
    check("halted_count", bus.fetch_count, exp_cnt(6));

    nRST = 1'b0;
    #1;
    check("async_rst_addr", bus.imemaddr, 32'h100);
    check("async_rst_ren", bus.imemREN, 32'h0);
    check("async_rst_count", bus.fetch_count, 32'h0);
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imemload = I0;
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    check("rst2_idle_ren", bus.imemREN, 32'h1);
    check("rst2_idle_addr", bus.imemaddr, 32'h100);
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    check("cnt10_addr", bus.imemaddr, 32'h128);
    check("cnt10_count", bus.fetch_count, exp_cnt(10));
    bus.pc_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check("cnt_hold_addr", bus.imemaddr, 32'h128);
    check("cnt_hold_count", bus.fetch_count, exp_cnt(10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
